serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor: computes diff = a - b - bin LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- Counterpart to the combinational 1-bit full-adder datapath: a sequential, multi-bit subtract path that reuses one cell over time.
- Start/busy/done handshake; sits between a controller FSM and a result register or ALU mux.

---
 rtl/serial_subtractor.sv | 160 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first, one bit per clock.
// Latency: accept at edge E0, done pulses in the cycle after E0+WIDTH; throughput one op per WIDTH+2 cycles.
// Backpressure: none; start is only honoured in IDLE, and requests during RUN/DONE are dropped, not queued.
//
// Ports: clk/rst (sync, active-high), start/a/b/bin request, busy/done status, diff/bout registered result.
// Optional: define SERIAL_SUB_OVF_EN to add the ovf output (two's-complement signed overflow).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are kept aside because the operand registers are shifted away during RUN.
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell operating on the current LSBs and the borrow flop.
  logic d_bit;
  logic br_next;
  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  // Partial result with the new bit shifted into the MSB; after the last bit this is the full result.
  logic [WIDTH-1:0] res_shift;
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_shift = d_bit;
    end else begin : g_wn
      assign res_shift = {d_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        res_d = res_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d  = res_shift;
          bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (amsb_q != bmsb_q) && (res_shift[WIDTH-1] != amsb_q);
`endif
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed-vector bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Inputs are driven and outputs sampled on the falling clock edge.
// Both instances share clock and reset; each test task checks its own expectations.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start1, a1, b1, bin1, busy1, done1, diff1, bout1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8;
  logic       ovf1;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .bin   (bin1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .bout  (bout1)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; returns at the falling edge right after the accepting edge E0.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic binv);
    @(negedge clk);
    a8 = av; b8 = bv; bin8 = binv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue1(input logic av, input logic bv, input logic binv);
    @(negedge clk);
    a1 = av; b1 = bv; bin1 = binv; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // Bounded wait for done; reports falling edges waited and how many of them showed busy.
  task automatic wait_done8(output int cyc, output int busy_n);
    cyc = 0; busy_n = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 === 1'b1) busy_n++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done1(output int cyc);
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({busy8, done8, diff8, bout8} !== 11'd0)
      $display("FAIL reset_w8: got busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8, bout8);
    else pass_cnt++;
    check_cnt++;
    if ({busy1, done1, diff1, bout1} !== 4'd0)
      $display("FAIL reset_w1: got %b, want 0000", {busy1, done1, diff1, bout1});
    else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
    check_cnt++;
    if (ovf8 !== 1'b0) $display("FAIL reset_ovf: got %b, want 0", ovf8);
    else pass_cnt++;
`endif
  endtask

  task automatic test_basic();
    int cyc, bn;
    issue8(8'h05, 8'h03, 1'b0);
    wait_done8(cyc, bn);
    check_cnt++;
    if (cyc !== 8) $display("FAIL basic_latency: got %0d, want 8", cyc); else pass_cnt++;
    check_cnt++;
    if (bn !== 8) $display("FAIL basic_busy_cycles: got %0d, want 8", bn); else pass_cnt++;
    check_cnt++;
    if (busy8 !== 1'b0) $display("FAIL basic_busy_at_done: got %b, want 0", busy8); else pass_cnt++;
    check_cnt++;
    if ({diff8, bout8} !== {8'h02, 1'b0})
      $display("FAIL basic_result: got diff=%h bout=%b, want diff=02 bout=0", diff8, bout8);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (done8 !== 1'b0) $display("FAIL basic_done_pulse: got %b, want 0", done8); else pass_cnt++;
  endtask

  task automatic test_borrow();
    int cyc, bn;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vi [3];
    logic [7:0] ed [3];
    logic       eb [3];
    logic [7:0] held;
    va = '{8'h03, 8'h00, 8'hFF};
    vb = '{8'h05, 8'h00, 8'h00};
    vi = '{1'b0, 1'b1, 1'b1};
    ed = '{8'hFE, 8'hFF, 8'hFE};
    eb = '{1'b1, 1'b1, 1'b0};
    held = 8'h02;
    for (int i = 0; i < 3; i++) begin
      issue8(va[i], vb[i], vi[i]);
      check_cnt++;
      if (diff8 !== held) $display("FAIL borrow_hold_%0d: got diff=%h, want %h", i, diff8, held);
      else pass_cnt++;
      wait_done8(cyc, bn);
      check_cnt++;
      if ({diff8, bout8} !== {ed[i], eb[i]})
        $display("FAIL borrow_vec_%0d: got diff=%h bout=%b, want diff=%h bout=%b", i, diff8, bout8, ed[i], eb[i]);
      else pass_cnt++;
      held = ed[i];
      @(negedge clk);
    end
  endtask

  task automatic test_width1();
    int cyc;
    logic [7:0] exp_d;
    logic [7:0] exp_b;
    logic [2:0] v;
    exp_d = 8'b1001_0110;
    exp_b = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      issue1(v[2], v[1], v[0]);
      wait_done1(cyc);
      check_cnt++;
      if (cyc !== 1 || diff1 !== exp_d[i] || bout1 !== exp_b[i])
        $display("FAIL w1_abc_%b: got cyc=%0d diff=%b bout=%b, want cyc=1 diff=%b bout=%b",
                 v, cyc, diff1, bout1, exp_d[i], exp_b[i]);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [7:0] got;
    issue8(8'h10, 8'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dones = 0; got = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (done8 === 1'b1) begin dones++; got = diff8; end
      @(negedge clk);
    end
    check_cnt++;
    if (dones !== 1) $display("FAIL ignore_done_count: got %0d, want 1", dones); else pass_cnt++;
    check_cnt++;
    if (got !== 8'h0F) $display("FAIL ignore_result: got diff=%h, want 0F", got); else pass_cnt++;
    check_cnt++;
    if (busy8 !== 1'b0) $display("FAIL ignore_idle: got busy=%b, want 0", busy8); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dones;
    @(negedge clk);
    a8 = 8'h09; b8 = 8'h04; bin8 = 1'b0; start8 = 1'b1;
    dones = 0;
    // Edge E0 follows; falling edges after E0..E0+19 see done after E0+8 and E0+18.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
    end
    start8 = 1'b0;
    check_cnt++;
    if (dones !== 2) $display("FAIL b2b_done_count: got %0d, want 2", dones); else pass_cnt++;
    check_cnt++;
    if (diff8 !== 8'h05) $display("FAIL b2b_result: got %h, want 05", diff8); else pass_cnt++;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones, cyc, bn;
    issue8(8'h10, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cnt++;
    if ({busy8, done8, diff8, bout8} !== 11'd0)
      $display("FAIL rstmid_outputs: got busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8, bout8);
    else pass_cnt++;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) dones++;
      @(negedge clk);
    end
    check_cnt++;
    if (dones !== 0) $display("FAIL rstmid_no_done: got %0d active cycles, want 0", dones); else pass_cnt++;
    issue8(8'h05, 8'h03, 1'b0);
    wait_done8(cyc, bn);
    check_cnt++;
    if (cyc !== 8 || diff8 !== 8'h02 || bout8 !== 1'b0)
      $display("FAIL rstmid_restart: got cyc=%0d diff=%h bout=%b, want cyc=8 diff=02 bout=0", cyc, diff8, bout8);
    else pass_cnt++;
    @(negedge clk);
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int cyc, bn;
    issue8(8'h80, 8'h01, 1'b0);
    wait_done8(cyc, bn);
    check_cnt++;
    if ({diff8, ovf8, bout8} !== {8'h7F, 1'b1, 1'b0})
      $display("FAIL ovf_set: got diff=%h ovf=%b bout=%b, want diff=7F ovf=1 bout=0", diff8, ovf8, bout8);
    else pass_cnt++;
    @(negedge clk);
    issue8(8'h05, 8'h03, 1'b0);
    check_cnt++;
    if (ovf8 !== 1'b1) $display("FAIL ovf_hold: got %b, want 1", ovf8); else pass_cnt++;
    wait_done8(cyc, bn);
    check_cnt++;
    if (ovf8 !== 1'b0) $display("FAIL ovf_clear: got %b, want 0", ovf8); else pass_cnt++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_width1();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
